record_writer: RTL and testbench



---
 rtl/record_writer.sv | 97 +++++++++
 tb/tb_record_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/record_writer.sv
// Avalon-MM write master: accepts one NDWORDS x 32-bit record and writes it to
// memory as 2*NDWORDS little-endian halfwords starting at baseaddr + index*record_size.
module record_writer #(
  parameter int NDWORDS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [31:0]             baseaddr,
  input  logic [31:0]             index,
  input  logic [32*NDWORDS-1:0]   data,
  input  logic                    ivalid,
  output logic                    iready,
  output logic                    odone,
  output logic                    avm_m0_write,
  output logic [31:0]             avm_m0_address,
  output logic [15:0]             avm_m0_writedata,
  output logic [1:0]              avm_m0_byteenable,
  input  logic                    avm_m0_waitrequest
);

  localparam int NHALF = 2 * NDWORDS;
  localparam int CNT_W = $clog2(NHALF) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NHALF - 1);
  localparam logic [31:0] REC_BYTES = 32'(NDWORDS * 4);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state, state_next;
  logic                    accept, xfer, last_xfer;
  logic [CNT_W-1:0]        k;
  logic [32*NDWORDS-1:0]   record;
  logic [31:0]             start_addr;

  // Halfword idx of the record; even idx is the low half of word idx>>1.
  function automatic logic [15:0] halfword(input logic [32*NDWORDS-1:0] rec,
                                           input logic [CNT_W-1:0] idx);
    return rec[16*idx +: 16];
  endfunction

  // Product is truncated to 32 bits, so the record address wraps modulo 2^32.
  assign start_addr = baseaddr + index * REC_BYTES;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next        = state;
    iready            = 1'b0;
    avm_m0_write      = 1'b0;
    avm_m0_byteenable = 2'b00;
    accept            = 1'b0;
    xfer              = 1'b0;
    last_xfer         = 1'b0;
    case (state)
      IDLE: begin
        iready = 1'b1;
        accept = ivalid;
        if (accept) state_next = WRITE;
      end
      WRITE: begin
        avm_m0_write      = 1'b1;
        avm_m0_byteenable = 2'b11;
        xfer              = !avm_m0_waitrequest;
        last_xfer         = xfer && (k == LAST);
        if (last_xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and data registers only move on accept or on a completed transfer,
  // which keeps them stable for the whole of a waitrequest stall.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      k                <= '0;
      record           <= '0;
      avm_m0_address   <= '0;
      avm_m0_writedata <= '0;
      odone            <= 1'b0;
    end else begin
      odone <= last_xfer;
      if (accept) begin
        record           <= data;
        k                <= '0;
        avm_m0_address   <= start_addr;
        avm_m0_writedata <= data[15:0];
      end else if (xfer && !last_xfer) begin
        k                <= k + CNT_W'(1);
        avm_m0_address   <= avm_m0_address + 32'd2;
        avm_m0_writedata <= halfword(record, k + CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_record_writer.sv
// Directed bench for record_writer (NDWORDS=4) with a logging Avalon slave that
// can stall chosen transfers.
module tb_record_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  baseaddr = '0;
  logic [31:0]  index = '0;
  logic [127:0] data = '0;
  logic         ivalid = 1'b0;
  logic         iready, odone, write, waitrequest;
  logic [31:0]  addr;
  logic [15:0]  wdata;
  logic [1:0]   be;

  record_writer #(.NDWORDS(4)) dut (
    .i_clk(clk), .i_rstn(rst_n), .baseaddr(baseaddr), .index(index), .data(data),
    .ivalid(ivalid), .iready(iready), .odone(odone), .avm_m0_write(write),
    .avm_m0_address(addr), .avm_m0_writedata(wdata), .avm_m0_byteenable(be),
    .avm_m0_waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Slave model and transfer log
  int cyc = 0, nlog = 0, nacc = 0, ndone = 0, nwcyc = 0, held_bad = 0;
  int xfer_idx = 0, stall_cnt = 0;
  int stall0 = -1, stall1 = -1;
  logic [31:0] log_addr [256];
  logic [15:0] log_data [256];
  logic [1:0]  log_be   [256];
  int          log_cyc  [256];
  int          acc_cyc  [64];
  int          done_cyc [64];
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  assign waitrequest = write && (xfer_idx == stall0 || xfer_idx == stall1) && (stall_cnt < 3);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (ivalid && iready) begin
        acc_cyc[nacc] <= cyc;
        nacc      <= nacc + 1;
        xfer_idx  <= 0;
        stall_cnt <= 0;
      end
      if (odone) begin
        done_cyc[ndone] <= cyc;
        ndone <= ndone + 1;
      end
      if (write) begin
        nwcyc <= nwcyc + 1;
        if (waitrequest) begin
          stall_cnt <= stall_cnt + 1;
          if (stall_cnt > 0 && (addr !== prev_addr || wdata !== prev_data))
            held_bad <= held_bad + 1;
        end else begin
          log_addr[nlog] <= addr;
          log_data[nlog] <= wdata;
          log_be[nlog]   <= be;
          log_cyc[nlog]  <= cyc;
          nlog      <= nlog + 1;
          xfer_idx  <= xfer_idx + 1;
          stall_cnt <= 0;
        end
        prev_addr <= addr;
        prev_data <= wdata;
      end
    end else begin
      xfer_idx  <= 0;
      stall_cnt <= 0;
    end
  end

  localparam logic [127:0] D1 = {32'h77778888, 32'h55556666, 32'h33334444, 32'h11112222};
  localparam logic [127:0] D2 = {32'hDDDDEEEE, 32'hBBBBCCCC, 32'h9999AAAA, 32'hA5A55A5A};
  logic [15:0] exp1 [8] = '{16'h2222, 16'h1111, 16'h4444, 16'h3333,
                            16'h6666, 16'h5555, 16'h8888, 16'h7777};

  task automatic offer(input logic [31:0] b, input logic [31:0] i, input logic [127:0] d);
    int n0;
    bit ok;
    @(negedge clk);
    baseaddr = b; index = i; data = d; ivalid = 1'b1;
    n0 = nacc; ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk); #1;
      if (nacc != n0) ok = 1'b1;
    end
    ivalid = 1'b0;
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 80 && !ok; c++) begin
      @(posedge clk); #1;
      if (ndone >= target) ok = 1'b1;
    end
    if (!ok) check_eq("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_rec(input string tag, input int b0, input logic [31:0] start,
                           input logic [127:0] d);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), log_addr[b0+i], start + 32'(2*i));
      check_eq($sformatf("%s_data%0d", tag, i), 32'(log_data[b0+i]), 32'(d[16*i +: 16]));
      check_eq($sformatf("%s_be%0d", tag, i), 32'(log_be[b0+i]), 32'd3);
    end
  endtask

  initial begin
    int a0, b0, d0, w0, hits;
    bit ok;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_iready", 32'(iready), 32'd1);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_odone", 32'(odone), 32'd0);
    check_eq("rst_be", 32'(be), 32'd0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_wdata", 32'(wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic record, no stalls
    a0 = nacc; b0 = nlog; d0 = ndone; w0 = nwcyc;
    offer(32'h1000, 32'd3, D1);
    wait_done(d0 + 1);
    check_eq("t1_nwrites", 32'(nlog - b0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t1_addr%0d", i), log_addr[b0+i], 32'h1030 + 32'(2*i));
      check_eq($sformatf("t1_data%0d", i), 32'(log_data[b0+i]), 32'(exp1[i]));
      check_eq($sformatf("t1_be%0d", i), 32'(log_be[b0+i]), 32'd3);
    end
    check_eq("t1_done_count", 32'(ndone - d0), 32'd1);
    check_eq("t1_done_latency", 32'(done_cyc[d0] - acc_cyc[a0]), 32'd9);
    check_eq("t1_write_cycles", 32'(nwcyc - w0), 32'd8);

    // Stalls of 3 cycles on transfers 0 and 5
    stall0 = 0; stall1 = 5;
    a0 = nacc; b0 = nlog; d0 = ndone; w0 = nwcyc;
    offer(32'h1000, 32'd3, D1);
    wait_done(d0 + 1);
    stall0 = -1; stall1 = -1;
    check_eq("t2_nwrites", 32'(nlog - b0), 32'd8);
    check_rec("t2", b0, 32'h1030, D1);
    check_eq("t2_write_cycles", 32'(nwcyc - w0), 32'd14);
    check_eq("t2_done_latency", 32'(done_cyc[d0] - acc_cyc[a0]), 32'd15);
    check_eq("t2_held_stable", 32'(held_bad), 32'd0);

    // Back-to-back: second accept lands in the odone cycle
    a0 = nacc; b0 = nlog; d0 = ndone;
    @(negedge clk);
    baseaddr = 32'h2000; index = 32'd0; data = D1; ivalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk); #1;
      if (nacc > a0) ok = 1'b1;
    end
    index = 32'd1; data = D2;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk); #1;
      if (nacc > a0 + 1) ok = 1'b1;
    end
    ivalid = 1'b0;
    if (!ok) check_eq("t3_accept_timeout", 32'd0, 32'd1);
    wait_done(d0 + 2);
    check_eq("t3_nwrites", 32'(nlog - b0), 32'd16);
    check_eq("t3_accept_in_done", 32'(acc_cyc[a0+1]), 32'(done_cyc[d0]));
    check_rec("t3a", b0, 32'h2000, D1);
    check_rec("t3b", b0 + 8, 32'h2010, D2);
    check_eq("t3_gap", 32'(log_cyc[b0+8] - log_cyc[b0+7]), 32'd2);

    // ivalid pulsed during WRITE is ignored
    a0 = nacc; b0 = nlog; d0 = ndone;
    offer(32'h1000, 32'd3, D2);
    @(negedge clk);
    @(negedge clk);
    index = 32'd7; data = D1; ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    wait_done(d0 + 1);
    check_eq("t4_accepts", 32'(nacc - a0), 32'd1);
    check_eq("t4_nwrites", 32'(nlog - b0), 32'd8);
    check_rec("t4", b0, 32'h1030, D2);
    hits = 0;
    for (int i = b0; i < nlog; i++)
      if (log_addr[i] >= 32'h1070 && log_addr[i] < 32'h1080) hits++;
    check_eq("t4_idx7_untouched", 32'(hits), 32'd0);

    // Address wrap
    b0 = nlog; d0 = ndone;
    offer(32'hFFFF_FFF0, 32'd1, D1);
    wait_done(d0 + 1);
    check_eq("t5_first_addr", log_addr[b0], 32'h0000_0000);
    check_eq("t5_last_addr", log_addr[b0+7], 32'h0000_000E);
    check_rec("t5", b0, 32'h0000_0000, D1);

    // Asynchronous reset after 3 accepted transfers
    b0 = nlog; d0 = ndone;
    offer(32'h1000, 32'd3, D1);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (nlog - b0 >= 3) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) check_eq("t6_progress_timeout", 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_write_dropped", 32'(write), 32'd0);
    check_eq("t6_iready", 32'(iready), 32'd1);
    check_eq("t6_be", 32'(be), 32'd0);
    check_eq("t6_addr", addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("t6_no_done", 32'(ndone - d0), 32'd0);
    check_eq("t6_partial", 32'(nlog - b0), 32'd3);
    b0 = nlog; d0 = ndone;
    offer(32'h3000, 32'd2, D2);
    wait_done(d0 + 1);
    check_eq("t6_nwrites", 32'(nlog - b0), 32'd8);
    check_rec("t6", b0, 32'h3020, D2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
